// File: rtl/mux_sel_ctrl_if.sv
// Request/grant bundle between the two channel requesters and mux_sel_ctrl.
// The master side drives requests and done, and the slave side returns select and grants.
interface mux_sel_ctrl_if;
    logic req_a;
    logic req_b;
    logic done;
    logic sel;
    logic gnt_a;
    logic gnt_b;
    logic busy;

    modport master (
        output req_a, req_b, done,
        input  sel, gnt_a, gnt_b, busy
    );

    modport slave (
        input  req_a, req_b, done,
        output sel, gnt_a, gnt_b, busy
    );
endinterface

// File: rtl/mux_sel_ctrl.sv
// Two-channel round-robin sequencer that drives the select input of a downstream 2:1 mux.
// A grant ends on done, on a request drop, or after MAX_HOLD cycles (legal range 1..255).
module mux_sel_ctrl #(
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    mux_sel_ctrl_if.slave bus
);
    // state   | meaning
    // IDLE    | no owner; sel keeps the last granted channel
    // GRANT_A | channel A owns the path, sel=0
    // GRANT_B | channel B owns the path, sel=1
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic       sel_q, sel_d;
    logic       last_q, last_d;
    logic [7:0] cnt_q, cnt_d;
    logic       gnt_a_q, gnt_a_d;
    logic       gnt_b_q, gnt_b_d;
    logic       busy_q, busy_d;
    logic       enter_a, enter_b;
    logic       hold_expired;

    assign hold_expired = (cnt_q == HOLD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= 8'd0;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        enter_a = 1'b0;
        enter_b = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_a && bus.req_b) begin
                    enter_a = last_q;
                    enter_b = !last_q;
                end else if (bus.req_a) begin
                    enter_a = 1'b1;
                end else if (bus.req_b) begin
                    enter_b = 1'b1;
                end
            end
            GRANT_A: begin
                if (bus.done || !bus.req_a || hold_expired) begin
                    // A still requesting without done means a timeout re-grant.
                    if (bus.req_b) begin
                        enter_b = 1'b1;
                    end else if (bus.req_a && !bus.done) begin
                        enter_a = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GRANT_B: begin
                if (bus.done || !bus.req_b || hold_expired) begin
                    if (bus.req_a) begin
                        enter_a = 1'b1;
                    end else if (bus.req_b && !bus.done) begin
                        enter_b = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (enter_a) begin
            state_d = GRANT_A;
            sel_d   = 1'b0;
            last_d  = 1'b0;
            cnt_d   = 8'd0;
        end else if (enter_b) begin
            state_d = GRANT_B;
            sel_d   = 1'b1;
            last_d  = 1'b1;
            cnt_d   = 8'd0;
        end
    end

    // Outputs are flops fed from the next state, so they change together with sel.
    assign gnt_a_d = (state_d == GRANT_A);
    assign gnt_b_d = (state_d == GRANT_B);
    assign busy_d  = gnt_a_d || gnt_b_d;

    assign bus.sel   = sel_q;
    assign bus.gnt_a = gnt_a_q;
    assign bus.gnt_b = gnt_b_q;
    assign bus.busy  = busy_q;

`ifndef SYNTHESIS
    a_grant_exclusive: assert property (@(posedge clk) disable iff (rst) !(gnt_a_q && gnt_b_q));
`endif
endmodule

// File: doc/mux_sel_ctrl.md
MUX_SEL_CTRL -- requirements
Module: mux_sel_ctrl

Purpose: 2-channel round-robin select sequencer; drives the select input of the downstream 2:1 mux (sel=0 passes channel A, sel=1 passes channel B).

Interface
REQ-001 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles per channel before forced release; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_a  input  1  channel A requests the mux path; level, held while data is pending.
REQ-005 req_b  input  1  channel B requests the mux path; level.
REQ-006 done  input  1  single-cycle pulse from the current owner ending its transfer.
REQ-007 sel  output  1  mux select: 0 = A, 1 = B; registered.
REQ-008 gnt_a  output  1  channel A owns the path; registered.
REQ-009 gnt_b  output  1  channel B owns the path; registered.
REQ-010 busy  output  1  high while either grant is high; registered.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, GRANT_A, GRANT_B; gnt_a=1 only in GRANT_A, gnt_b=1 only in GRANT_B; gnt_a and gnt_b never high together.
REQ-012 An internal last-owner bit SHALL record the most recently granted channel; it updates on every grant entry.
REQ-013 IDLE: req_a only -> GRANT_A; req_b only -> GRANT_B; both -> the channel that is not last-owner; neither -> stay IDLE.
REQ-014 Latency: a request sampled at edge N SHALL show its grant and the matching sel value from edge N onward (visible in cycle N+1); sel and grant change on the same edge.
REQ-015 An 8-bit hold counter SHALL clear on every grant entry and increment once per cycle while in a GRANT state.
REQ-016 A GRANT_X release condition SHALL be: done=1, OR req_X=0, OR counter = MAX_HOLD-1; simultaneous conditions SHALL produce a single release.
REQ-017 On release, if the other channel is requesting, the FSM SHALL move directly to the other GRANT state on the same edge with no IDLE cycle.
REQ-018 On release by timeout with only the owner requesting, the FSM SHALL re-grant the same channel, clearing the counter; gnt stays high without a gap.
REQ-019 On release by done or by the owner dropping req with no other request, the FSM SHALL return to IDLE.
REQ-020 In IDLE, sel SHALL hold its last value; sel changes only on a grant entry.
REQ-021 done received in IDLE SHALL be ignored.
REQ-022 With MAX_HOLD=1, every grant SHALL last exactly one cycle, and two persistent requesters SHALL alternate every cycle.
REQ-023 busy SHALL equal gnt_a OR gnt_b, registered (no combinational path from inputs to any output).

Reset
REQ-024 While rst=1, regardless of clk: state=IDLE, sel=0, gnt_a=0, gnt_b=0, busy=0, counter=0, last-owner=B (A wins the first tie).
REQ-025 Reset asserted mid-grant SHALL drop the grant immediately (asynchronously); after release, arbitration restarts from REQ-024 values.
REQ-026 Requests present during the first edge after rst falls SHALL be arbitrated normally on that edge.

Verification
REQ-027 Reset then req_a=req_b=1 held, MAX_HOLD=8 -> gnt_a for 8 cycles (sel=0), then gnt_b for 8 cycles (sel=1), alternating, no idle gap, never both grants high.
REQ-028 req_b=1 alone, done pulse in 3rd grant cycle, req_b dropped the same cycle -> gnt_b high exactly 3 cycles, then IDLE, sel stays 1, busy 0.
REQ-029 req_a=1 alone held 20 cycles, MAX_HOLD=8 -> gnt_a continuous for 20 cycles (re-grants at cycles 8 and 16), sel=0 throughout.
REQ-030 GRANT_A active, req_b rises, done pulses in cycle 2 -> gnt_a falls and gnt_b rises on the same edge; sel 0->1 on that edge.
REQ-031 rst pulsed asynchronously mid-GRANT_B -> gnt_b, busy, sel fall to 0 without waiting for clk; after release with both requests high, A is granted first.
REQ-032 done pulses in IDLE with no requests -> no state or output change.
